// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: assembles little-endian words into instruction RAM, then releases the core.
// Optional checksum byte after the image is enabled by defining IMEM_BOOT_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int I_ADDR_BITS = 6,
  parameter int INSTR_SIZE  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   rx_ready,
  input  logic                   reload,
  input  logic [I_ADDR_BITS-1:0] i_mem_addr,
  output logic [INSTR_SIZE-1:0]  i_mem_data,
  output logic                   cpu_rst_n,
  output logic                   load_done,
  output logic                   load_err
);

  localparam int DEPTH = 2 ** I_ADDR_BITS;
  localparam int LEN_W = I_ADDR_BITS + 1;

`ifdef IMEM_BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_RUN, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_LEN, S_DATA, S_RUN, S_ERR} state_t;
`endif

  state_t                 state;
  logic [LEN_W-1:0]       len;
  logic [1:0]             byte_cnt;
  logic [I_ADDR_BITS-1:0] word_ptr;
  logic [23:0]            lanes;
  logic                   accept;
  logic                   hdr_bad;
  logic                   last_word;
  logic                   ram_we;
  logic [INSTR_SIZE-1:0]  ram [DEPTH];
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0]             csum;
`endif

  always_comb begin
    rx_ready = 1'b0;
    case (state)
      S_LEN, S_DATA: rx_ready = 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
      S_CSUM:        rx_ready = 1'b1;
`endif
      default:       rx_ready = 1'b0;
    endcase
  end

  assign accept    = rx_valid && rx_ready;
  assign hdr_bad   = (rx_data == '0) || (32'(rx_data) > DEPTH);
  assign last_word = (byte_cnt == 2'd3) && (LEN_W'(word_ptr) == len - LEN_W'(1));
  // reload wins over a coincident byte, so the RAM write is suppressed too
  assign ram_we    = accept && !reload && (state == S_DATA) && (byte_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (ram_we) ram[word_ptr] <= {rx_data, lanes};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_LEN;
      len       <= '0;
      byte_cnt  <= '0;
      word_ptr  <= '0;
      lanes     <= '0;
      cpu_rst_n <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      csum      <= '0;
`endif
    end else if (reload) begin
      state     <= S_LEN;
      len       <= '0;
      byte_cnt  <= '0;
      word_ptr  <= '0;
      lanes     <= '0;
      cpu_rst_n <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      case (state)
        S_LEN: begin
`ifdef IMEM_BOOT_CHECKSUM_EN
          csum <= '0;
`endif
          if (accept) begin
            if (hdr_bad) begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end else begin
              len      <= LEN_W'(rx_data);
              word_ptr <= '0;
              byte_cnt <= '0;
              state    <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum     <= csum ^ rx_data;
`endif
            case (byte_cnt)
              2'd0: lanes[7:0]   <= rx_data;
              2'd1: lanes[15:8]  <= rx_data;
              2'd2: lanes[23:16] <= rx_data;
              default: begin
                word_ptr <= word_ptr + 1'b1;
                if (last_word) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                  state     <= S_CSUM;
`else
                  state     <= S_RUN;
                  cpu_rst_n <= 1'b1;
                  load_done <= 1'b1;
`endif
                end
              end
            endcase
          end
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            if (rx_data == csum) begin
              state     <= S_RUN;
              cpu_rst_n <= 1'b1;
              load_done <= 1'b1;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
        end
`endif
        S_RUN: begin
          cpu_rst_n <= 1'b1;
          load_done <= 1'b1;
        end
        default: begin
          cpu_rst_n <= 1'b0;
          load_done <= 1'b0;
          load_err  <= 1'b1;
        end
      endcase
    end
  end

  // addresses at or beyond len read as zero so stale RAM from an earlier image never leaks
  always_comb begin
    i_mem_data = '0;
    if ((state == S_RUN) && (LEN_W'(i_mem_addr) < len)) i_mem_data = ram[i_mem_addr];
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed vector table, hand sequences, randomized images vs a byte-queue model.
module tb_imem_boot_loader;

  localparam int AB    = 6;
  localparam int DEPTH = 64;
`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam int CS_BYTES = 1;
`else
  localparam int CS_BYTES = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_ready;
  logic          reload = 1'b0;
  logic [AB-1:0] i_mem_addr = '0;
  logic [31:0]   i_mem_data;
  logic          cpu_rst_n;
  logic          load_done;
  logic          load_err;

  imem_boot_loader #(.I_ADDR_BITS(AB), .INSTR_SIZE(32)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .reload(reload), .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data),
    .cpu_rst_n(cpu_rst_n), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: the accepted bytes of the current image, plus done/error flags.
  logic [7:0] img[$];
  bit         m_err;
  bit         m_done;

  function automatic void model_clear();
    img.delete();
    m_err  = 1'b0;
    m_done = 1'b0;
  endfunction

  function automatic bit m_ready();
    return !m_err && !m_done;
  endfunction

  function automatic void model_edge(logic v, logic [7:0] d, logic rl);
    int n;
    logic [7:0] x;
    if (rl) begin
      model_clear();
    end else if (v && m_ready()) begin
      img.push_back(d);
      n = int'(img[0]);
      if (img.size() == 1) begin
        if (n == 0 || n > DEPTH) m_err = 1'b1;
      end else if (img.size() == 1 + 4 * n + CS_BYTES) begin
        x = '0;
        for (int i = 1; i <= 4 * n; i++) x = x ^ img[i];
        if (CS_BYTES == 1 && x != img[img.size() - 1]) m_err = 1'b1;
        else m_done = 1'b1;
      end
    end
  endfunction

  function automatic logic [31:0] exp_word(int a);
    if (!m_done || a >= int'(img[0])) return 32'h0;
    return {img[4*a+4], img[4*a+3], img[4*a+2], img[4*a+1]};
  endfunction

  task automatic step(input logic v, input logic [7:0] d, input logic rl);
    rx_valid = v;
    rx_data  = d;
    reload   = rl;
    model_edge(v, d, rl);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    reload   = 1'b0;
  endtask

  task automatic check_ctrl(input string tag);
    check({tag, ".rx_ready"},  32'(rx_ready),  32'(m_ready()));
    check({tag, ".cpu_rst_n"}, 32'(cpu_rst_n), 32'(m_done));
    check({tag, ".load_done"}, 32'(load_done), 32'(m_done));
    check({tag, ".load_err"},  32'(load_err),  32'(m_err));
  endtask

  task automatic check_reads(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      i_mem_addr = AB'(a);
      @(negedge clk);
      check($sformatf("%s.rd[%0d]", tag, a), i_mem_data, exp_word(a));
    end
  endtask

  logic [7:0] stim[$];

  function automatic void build_image(int n, bit corrupt);
    logic [7:0] b;
    logic [7:0] x;
    stim.delete();
    stim.push_back(8'(n));
    x = '0;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      x = x ^ b;
      stim.push_back(b);
    end
    if (CS_BYTES == 1) stim.push_back(corrupt ? (x ^ 8'h5A) : x);
  endfunction

  task automatic feed_stim(input bit rand_valid, input int bound, input string tag);
    int  idx;
    int  cyc;
    bit  acc;
    logic v;
    logic [7:0] d;
    idx = 0;
    cyc = 0;
    while (idx < stim.size() && !m_err && cyc < bound) begin
      v   = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      d   = v ? stim[idx] : 8'($urandom);
      acc = v && m_ready();
      step(v, d, 1'b0);
      check_ctrl(tag);
      if (acc) idx++;
      cyc++;
    end
    n_cmp++;
    if (cyc >= bound) begin
      n_mis++;
      $display("FAIL %s.timeout: got %0d cycles expected < %0d", tag, cyc, bound);
    end
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rl;
    int          addr;
    logic        rdy;
    logic        cpu;
    logic        done;
    logic        err;
    logic [31:0] dat;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic v, logic [7:0] d, logic rl, int addr,
                              logic rdy, logic cpu, logic done, logic err, logic [31:0] dat);
    vec_t r;
    r = '{v, d, rl, addr, rdy, cpu, done, err, dat};
    tbl.push_back(r);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst.rx_ready", 32'(rx_ready), 32'h1);
    check("rst.cpu_rst_n", 32'(cpu_rst_n), 32'h0);
    check("rst.load_done", 32'(load_done), 32'h0);
    check("rst.load_err", 32'(load_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check_reads("rst");

    // reference image: 02, 0x00000013, 0x005000B3
    add(1, 8'h02, 0, 0, 1, 0, 0, 0, 0);
    add(1, 8'h13, 0, 0, 1, 0, 0, 0, 0);
    add(0, 8'hAA, 0, 0, 1, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0, 1, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0, 1, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0, 1, 0, 0, 0, 0);
    add(1, 8'hB3, 0, 0, 1, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0, 1, 0, 0, 0, 0);
    add(1, 8'h50, 0, 0, 1, 0, 0, 0, 0);
`ifdef IMEM_BOOT_CHECKSUM_EN
    add(1, 8'h00, 0, 0, 1, 0, 0, 0, 0);
    add(1, 8'h13 ^ 8'hB3 ^ 8'h50, 0, 0, 0, 1, 1, 0, 32'h0000_0013);
`else
    add(1, 8'h00, 0, 0, 0, 1, 1, 0, 32'h0000_0013);
`endif
    add(0, 8'h00, 0, 1, 0, 1, 1, 0, 32'h0050_00B3);
    add(0, 8'h00, 0, 2, 0, 1, 1, 0, 32'h0000_0000);
    add(1, 8'hFF, 0, 0, 0, 1, 1, 0, 32'h0000_0013);
    add(1, 8'h05, 1, 0, 1, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0, 1, 0);
    add(1, 8'h02, 0, 0, 0, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 1, 0, 0, 0, 0);
    add(1, 8'h41, 0, 0, 0, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 1, 0, 0, 0, 0);
    add(1, 8'h01, 0, 0, 1, 0, 0, 0, 0);
    add(1, 8'h6F, 1, 0, 1, 0, 0, 0, 0);
    add(1, 8'h01, 0, 0, 1, 0, 0, 0, 0);
    add(1, 8'h6F, 0, 0, 1, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0, 1, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0, 1, 0, 0, 0, 0);
`ifdef IMEM_BOOT_CHECKSUM_EN
    add(1, 8'h00, 0, 0, 1, 0, 0, 0, 0);
    add(1, 8'h6F, 0, 0, 0, 1, 1, 0, 32'h0000_006F);
`else
    add(1, 8'h00, 0, 0, 0, 1, 1, 0, 32'h0000_006F);
`endif
    add(0, 8'h00, 0, 1, 0, 1, 1, 0, 32'h0000_0000);

    for (int i = 0; i < tbl.size(); i++) begin
      i_mem_addr = AB'(tbl[i].addr);
      step(tbl[i].v, tbl[i].d, tbl[i].rl);
      check($sformatf("tbl[%0d].rx_ready", i), 32'(rx_ready), 32'(tbl[i].rdy));
      check($sformatf("tbl[%0d].cpu_rst_n", i), 32'(cpu_rst_n), 32'(tbl[i].cpu));
      check($sformatf("tbl[%0d].load_done", i), 32'(load_done), 32'(tbl[i].done));
      check($sformatf("tbl[%0d].load_err", i), 32'(load_err), 32'(tbl[i].err));
      check($sformatf("tbl[%0d].i_mem_data", i), i_mem_data, tbl[i].dat);
    end

    // async reset in the middle of a full-depth load
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h40, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    check("arst.rx_ready", 32'(rx_ready), 32'h1);
    check("arst.cpu_rst_n", 32'(cpu_rst_n), 32'h0);
    check("arst.load_done", 32'(load_done), 32'h0);
    #1;
    rst_n = 1'b1;
    build_image(DEPTH, 1'b0);
    feed_stim(1'b0, 2000, "full");
    check("full.load_done", 32'(load_done), 32'h1);
    check_reads("full");
`ifdef IMEM_BOOT_CHECKSUM_EN
    step(1'b0, 8'h00, 1'b1);
    build_image(DEPTH, 1'b1);
    feed_stim(1'b0, 2000, "badcs");
    check("badcs.load_err", 32'(load_err), 32'h1);
    check_reads("badcs");
`endif

    for (int r = 0; r < 14; r++) begin
      int n;
      step(1'b0, 8'h00, 1'b1);
      check_ctrl("rnd.reload");
      if (r % 6 == 5) n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(DEPTH + 1, 255);
      else n = $urandom_range(1, DEPTH);
      build_image(n, $urandom_range(0, 3) == 0);
      feed_stim(1'b1, 4000, $sformatf("rnd%0d", r));
      check_reads($sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
